// File: rtl/fetch_queue.sv
// Instruction fetch front end: single-outstanding memory fetcher feeding a
// small FIFO of {pc, instruction} pairs toward the IF/ID register.
//
// state  | meaning
// FETCH  | nothing outstanding; may issue a request
// WAIT   | one granted request outstanding; its response is kept
// DROP   | one request outstanding whose response must be thrown away
module fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        out_ready,
    output logic        out_valid,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    output logic [31:0] out_nextpc
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW:0] DEPTH_C = (CW + 1)'(DEPTH);

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_WAIT  = 2'd1,
        S_DROP  = 2'd2
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [31:0]   r_fetch_pc;
    logic [31:0]   w_fetch_pc_nxt;
    logic [31:0]   r_req_addr;
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic [31:0]   r_mem_pc    [DEPTH];
    logic [31:0]   r_mem_instr [DEPTH];

    logic          w_head_valid;
    logic          w_resp_clear;
    logic          w_in_flight;
    logic [CW:0]   w_occ;
    logic          w_grant;
    logic          w_push;
    logic          w_pop;
    logic          w_unused;

    assign w_unused = ^redirect_pc[1:0];

    assign w_head_valid = (r_count != '0);

    // The slot is free for a new request when nothing is outstanding or the
    // outstanding response lands this very cycle.
    assign w_resp_clear = (r_state == S_FETCH) || imem_rvalid;
    // A kept response in flight already owns a queue slot; a dropped one does not.
    assign w_in_flight  = (r_state == S_WAIT);
    assign w_occ        = {1'b0, r_count} + (CW + 1)'(w_in_flight);

    assign imem_req  = !reset && !redirect_valid && w_resp_clear && (w_occ < DEPTH_C);
    assign imem_addr = r_fetch_pc;
    assign w_grant   = imem_req && imem_gnt;

    assign w_push = (r_state == S_WAIT) && imem_rvalid && !redirect_valid;
    assign w_pop  = w_head_valid && out_ready && !redirect_valid;

    always_comb begin
        w_state_nxt    = r_state;
        w_fetch_pc_nxt = r_fetch_pc;
        if (redirect_valid) begin
            w_fetch_pc_nxt = {redirect_pc[31:2], 2'b00};
            if ((r_state != S_FETCH) && !imem_rvalid) begin
                w_state_nxt = S_DROP;
            end else begin
                w_state_nxt = S_FETCH;
            end
        end else begin
            if (w_grant) begin
                w_fetch_pc_nxt = r_fetch_pc + 32'd4;
            end
            case (r_state)
                S_FETCH: begin
                    if (w_grant) begin
                        w_state_nxt = S_WAIT;
                    end
                end
                S_WAIT, S_DROP: begin
                    if (imem_rvalid) begin
                        w_state_nxt = w_grant ? S_WAIT : S_FETCH;
                    end
                end
                default: w_state_nxt = S_FETCH;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_FETCH;
            r_fetch_pc <= RESET_PC;
            r_req_addr <= RESET_PC;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_fetch_pc <= w_fetch_pc_nxt;
            if (w_grant) begin
                r_req_addr <= r_fetch_pc;
            end
            if (redirect_valid) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
                r_count  <= '0;
            end else begin
                if (w_push) begin
                    r_wr_ptr <= r_wr_ptr + PW'(1);
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + PW'(1);
                end
                case ({w_push, w_pop})
                    2'b10:   r_count <= r_count + CW'(1);
                    2'b01:   r_count <= r_count - CW'(1);
                    default: r_count <= r_count;
                endcase
            end
        end
    end

    // Storage carries no reset: entries are only visible while counted.
    always_ff @(posedge clk) begin
        if (w_push && !reset) begin
            r_mem_pc[r_wr_ptr]    <= r_req_addr;
            r_mem_instr[r_wr_ptr] <= imem_rdata;
        end
    end

    assign out_valid  = w_head_valid;
    assign out_instr  = w_head_valid ? r_mem_instr[r_rd_ptr] : 32'h0000_0000;
    assign out_pc     = w_head_valid ? r_mem_pc[r_rd_ptr] : 32'h0000_0000;
    assign out_nextpc = out_pc + 32'd4;

endmodule
